// File: rtl/fft_p_s_out_if.sv
// Frame-load / serial-output bundle between the FFT result stage and the serial consumer.
// The master side presents frames; the slave side (the converter) streams words out.
interface fft_p_s_out_if #(
  parameter int N = 8,
  parameter int W = 34
);
  logic           load;
  logic [N*W-1:0] data_in;
  logic           ready;
  logic [W-1:0]   data_out;
  logic           out_valid;
  logic           frame_start;
  logic           frame_end;
  logic           overrun;

  modport master (
    output load, data_in,
    input  ready, data_out, out_valid, frame_start, frame_end, overrun
  );

  modport slave (
    input  load, data_in,
    output ready, data_out, out_valid, frame_start, frame_end, overrun
  );
endinterface

// File: rtl/fft_p_s_out.sv
// Parallel-to-serial FFT output converter: one frame loaded per strobe, streamed one word
// per clock in natural frequency order, with a shadow buffer for gap-free back-to-back frames.
module fft_p_s_out #(
  parameter int N      = 8,
  parameter int W      = 34,
  parameter int BITREV = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  fft_p_s_out_if.slave  bus
);
  localparam int              LOG2N = $clog2(N);
  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [LOG2N-1:0] cnt;
  logic [LOG2N-1:0] rd_idx;
  logic             shadow_full;
  logic [W-1:0]     active [N];
  logic [W-1:0]     shadow [N];

  logic last_word;
  logic take_shadow;
  logic take_direct;
  logic fill_shadow;
  logic load_idle;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] k);
    logic [LOG2N-1:0] r;
    for (int b = 0; b < LOG2N; b++) begin
      r[b] = k[LOG2N-1-b];
    end
    return r;
  endfunction

  assign bus.ready   = !shadow_full;
  assign last_word   = (state == SHIFT) && (cnt == LAST);
  assign take_shadow = last_word && shadow_full;
  assign take_direct = last_word && !shadow_full && bus.load;
  assign fill_shadow = (state == SHIFT) && !last_word && !shadow_full && bus.load;
  assign load_idle   = (state == IDLE) && bus.load;
  assign rd_idx      = (BITREV != 0) ? bitrev(cnt) : cnt;

  // Frame storage: contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (load_idle || take_direct) begin
        active[i] <= bus.data_in[i*W +: W];
      end else if (take_shadow) begin
        active[i] <= shadow[i];
      end
      if (fill_shadow) begin
        shadow[i] <= bus.data_in[i*W +: W];
      end
    end
  end

  // Control and registered serial output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      shadow_full     <= 1'b0;
      bus.data_out    <= '0;
      bus.out_valid   <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.frame_end   <= 1'b0;
      bus.overrun     <= 1'b0;
    end else begin
      bus.overrun <= bus.load && shadow_full;
      case (state)
        IDLE: begin
          bus.data_out    <= '0;
          bus.out_valid   <= 1'b0;
          bus.frame_start <= 1'b0;
          bus.frame_end   <= 1'b0;
          if (bus.load) begin
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          bus.data_out    <= active[rd_idx];
          bus.out_valid   <= 1'b1;
          bus.frame_start <= (cnt == '0);
          bus.frame_end   <= (cnt == LAST);
          cnt             <= cnt + 1'b1;
          if (cnt == LAST) begin
            // cnt wraps to 0 on its own; only the empty-handed case leaves SHIFT.
            if (shadow_full) begin
              shadow_full <= 1'b0;
            end else if (!bus.load) begin
              state <= IDLE;
            end
          end else if (bus.load && !shadow_full) begin
            shadow_full <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
